// File: rtl/mem_access_unit.sv
// Memory-access stage: drives a single-outstanding request/ack data port, steers store lanes,
// extracts and extends load data, and flags misaligned accesses and bus timeouts.
module mem_access_unit #(
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch_in,
    input  logic                zero_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic [2:0]          funct3_in,
    input  logic [DATA_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata_in,
    output logic                pc_src_out,
    output logic                dmem_req_out,
    output logic                dmem_we_out,
    output logic [DATA_W-1:0]   dmem_addr_out,
    output logic [DATA_W-1:0]   dmem_wdata_out,
    output logic [DATA_W/8-1:0] dmem_wstrb_out,
    input  logic                dmem_ack_in,
    input  logic [DATA_W-1:0]   dmem_rdata_in,
    output logic                stall_out,
    output logic [DATA_W-1:0]   load_data_out,
    output logic                load_valid_out,
    output logic                misaligned_out,
    output logic                bus_error_out
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic                r_req;
    logic                r_we;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [OFF_W-1:0]    r_off;
    logic [2:0]          r_funct3;
    logic [DATA_W-1:0]   r_loadData;
    logic                r_loadValid;
    logic                r_busError;

    logic                w_req;
    logic                w_misal;
    logic [OFF_W-1:0]    w_off;
    logic [STRB_W-1:0]   w_mask;
    logic [STRB_W-1:0]   w_wstrb;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_shift;
    logic [DATA_W-1:0]   w_loadData;

    assign pc_src_out = branch_in & zero_in;
    assign w_req      = mem_read_in | mem_write_in;
    assign w_off      = addr_in[OFF_W-1:0];
    assign w_wstrb    = w_mask << w_off;
    assign w_wdata    = wdata_in << {w_off, 3'b000};
    assign w_shift    = dmem_rdata_in >> {r_off, 3'b000};

    // Access size comes from funct3[1:0] for both alignment checking and strobe generation.
    always_comb begin
        w_misal = 1'b0;
        w_mask  = {STRB_W{1'b1}};
        case (funct3_in[1:0])
            2'b00: w_mask = STRB_W'(1);
            2'b01: begin
                w_mask  = STRB_W'(3);
                w_misal = w_off[0];
            end
            2'b10: begin
                w_mask  = STRB_W'(15);
                w_misal = |w_off[1:0];
            end
            default: w_misal = |w_off;
        endcase
    end

    always_comb begin
        w_loadData = '0;
        case (r_funct3)
            3'b000:  w_loadData = {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_loadData = {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_loadData = {{(DATA_W-32){w_shift[31]}}, w_shift[31:0]};
            3'b011:  w_loadData = w_shift;
            3'b100:  w_loadData = {{(DATA_W-8){1'b0}}, w_shift[7:0]};
            3'b101:  w_loadData = {{(DATA_W-16){1'b0}}, w_shift[15:0]};
            3'b110:  w_loadData = {{(DATA_W-32){1'b0}}, w_shift[31:0]};
            default: w_loadData = '0;
        endcase
    end

    // Stall and misalignment are decoded live from the IDLE request so the pipeline reacts in-cycle.
    always_comb begin
        stall_out      = 1'b0;
        misaligned_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    misaligned_out = w_misal;
                    stall_out      = ~w_misal;
                end
            end
            S_ACCESS: stall_out = 1'b1;
            default:  stall_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_loadData  <= '0;
            r_loadValid <= 1'b0;
            r_busError  <= 1'b0;
        end else begin
            r_loadValid <= 1'b0;
            r_busError  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_misal) begin
                        r_req    <= 1'b1;
                        r_we     <= mem_write_in;
                        r_addr   <= {addr_in[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
                        r_wdata  <= w_wdata;
                        r_wstrb  <= w_wstrb;
                        r_off    <= w_off;
                        r_funct3 <= funct3_in;
                        r_count  <= '0;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // An ack in the same cycle as the timeout limit wins over the error.
                    if (dmem_ack_in) begin
                        r_req   <= 1'b0;
                        r_state <= S_RESP;
                        if (!r_we) begin
                            r_loadData  <= w_loadData;
                            r_loadValid <= 1'b1;
                        end
                    end else if (r_count == CNT_W'(TIMEOUT_CYCLES)) begin
                        r_req      <= 1'b0;
                        r_busError <= 1'b1;
                        r_state    <= S_RESP;
                        if (!r_we) begin
                            r_loadData  <= '0;
                            r_loadValid <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmem_req_out   = r_req;
    assign dmem_we_out    = r_we;
    assign dmem_addr_out  = r_addr;
    assign dmem_wdata_out = r_wdata;
    assign dmem_wstrb_out = r_wstrb;
    assign load_data_out  = r_loadData;
    assign load_valid_out = r_loadValid;
    assign bus_error_out  = r_busError;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by random transactions,
// all checked against an arithmetic model of loads, stores, alignment and timeout.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_in, zero_in, mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [63:0] addr_in, wdata_in;
    logic        pc_src_out, dmem_req_out, dmem_we_out;
    logic [63:0] dmem_addr_out, dmem_wdata_out;
    logic [7:0]  dmem_wstrb_out;
    logic        dmem_ack_in;
    logic [63:0] dmem_rdata_in;
    logic        stall_out;
    logic [63:0] load_data_out;
    logic        load_valid_out, misaligned_out, bus_error_out;

    int          tests  = 0;
    int          failed = 0;
    logic [63:0] expLoad = '0;

    mem_access_unit #(.DATA_W(64), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .branch_in(branch_in), .zero_in(zero_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .pc_src_out(pc_src_out),
        .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
        .dmem_wstrb_out(dmem_wstrb_out),
        .dmem_ack_in(dmem_ack_in), .dmem_rdata_in(dmem_rdata_in),
        .stall_out(stall_out),
        .load_data_out(load_data_out), .load_valid_out(load_valid_out),
        .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] loadModel(input logic [2:0] f3, input int off, input logic [63:0] rdat);
        logic [63:0] v;
        logic [63:0] m;
        int          nb;
        v  = rdat >> (8 * off);
        nb = 1 << (int'(f3) % 4);
        if (f3 == 3'd7) return 64'd0;
        if (nb < 8) begin
            m = (64'd1 << (8 * nb)) - 64'd1;
            v = v & m;
            if (f3 < 3'd4 && v[8*nb-1]) v = v | ~m;
        end
        return v;
    endfunction

    function automatic logic [7:0] strobeModel(input logic [2:0] f3, input int off);
        logic [15:0] s;
        s = ((16'd1 << (1 << (int'(f3) % 4))) - 16'd1) << off;
        return s[7:0];
    endfunction

    // One complete instruction: present it in IDLE, answer after ackDelay ACCESS cycles
    // (beyond TO means never), then check RESP and the following idle cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] wd,
                                 input logic [63:0] rdat, input int ackDelay);
        logic isReq, isStore, mis, timeout;
        int   off, nb, nAcc;
        isReq   = rd | wr;
        isStore = wr;
        off     = int'(a[2:0]);
        nb      = 1 << int'(f3[1:0]);
        mis     = isReq && ((a % 64'(nb)) != 64'd0);
        timeout = ackDelay > TO;
        nAcc    = timeout ? TO + 1 : ackDelay + 1;

        mem_read_in  = rd;
        mem_write_in = wr;
        funct3_in    = f3;
        addr_in      = a;
        wdata_in     = wd;
        dmem_ack_in  = 1'b0;
        #1;
        checkOutput("stall_idle", stall_out, isReq && !mis);
        checkOutput("misaligned", misaligned_out, mis);
        @(posedge clk); #1;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        addr_in      = {$urandom, $urandom};
        wdata_in     = {$urandom, $urandom};
        if (!isReq || mis) begin
            checkOutput("no_req", dmem_req_out, 1'b0);
            checkOutput("no_valid", load_valid_out, 1'b0);
            return;
        end
        for (int i = 0; i < nAcc; i++) begin
            checkOutput("acc_req", dmem_req_out, 1'b1);
            checkOutput("acc_stall", stall_out, 1'b1);
            checkOutput("acc_we", dmem_we_out, isStore);
            checkOutput("acc_addr", dmem_addr_out, a & ~64'h7);
            checkOutput("acc_valid", load_valid_out, 1'b0);
            if (isStore) begin
                checkOutput("acc_wstrb", dmem_wstrb_out, strobeModel(f3, off));
                checkOutput("acc_wdata", dmem_wdata_out, wd << (8 * off));
            end
            dmem_ack_in   = (i == ackDelay);
            dmem_rdata_in = (i == ackDelay) ? rdat : {$urandom, $urandom};
            @(posedge clk); #1;
            dmem_ack_in = 1'b0;
        end
        if (!isStore) expLoad = timeout ? 64'd0 : loadModel(f3, off, rdat);
        checkOutput("resp_req", dmem_req_out, 1'b0);
        checkOutput("resp_stall", stall_out, 1'b0);
        checkOutput("resp_valid", load_valid_out, !isStore);
        checkOutput("resp_buserr", bus_error_out, timeout);
        checkOutput("resp_data", load_data_out, expLoad);
        @(posedge clk); #1;
        checkOutput("post_valid", load_valid_out, 1'b0);
        checkOutput("post_buserr", bus_error_out, 1'b0);
        checkOutput("post_stall", stall_out, 1'b0);
        checkOutput("post_data", load_data_out, expLoad);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        logic        rd, wr;

        reset = 1'b1; branch_in = 1'b0; zero_in = 1'b0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'd0;
        addr_in = '0; wdata_in = '0; dmem_ack_in = 1'b0; dmem_rdata_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_req", dmem_req_out, 1'b0);
        checkOutput("rst_we", dmem_we_out, 1'b0);
        checkOutput("rst_wstrb", dmem_wstrb_out, 8'h00);
        checkOutput("rst_addr", dmem_addr_out, 64'd0);
        checkOutput("rst_wdata", dmem_wdata_out, 64'd0);
        checkOutput("rst_data", load_data_out, 64'd0);
        checkOutput("rst_valid", load_valid_out, 1'b0);
        checkOutput("rst_buserr", bus_error_out, 1'b0);
        checkOutput("rst_stall", stall_out, 1'b0);

        branch_in = 1'b1; zero_in = 1'b1; #1;
        checkOutput("pc_src_taken", pc_src_out, 1'b1);
        zero_in = 1'b0; #1;
        checkOutput("pc_src_not_taken", pc_src_out, 1'b0);
        branch_in = 1'b0;

        applyStimulus(1'b1, 1'b0, 3'b010, 64'h1004, 64'd0, 64'h80000000_00000000, 0);
        checkOutput("lw_literal", load_data_out, 64'hFFFFFFFF_80000000);
        applyStimulus(1'b0, 1'b1, 3'b000, 64'h2003, 64'hAB, 64'd0, 2);
        applyStimulus(1'b1, 1'b0, 3'b001, 64'h11, 64'd0, 64'd0, 0);
        applyStimulus(1'b1, 1'b0, 3'b011, 64'h3000, 64'd0, 64'h1234_5678_9ABC_DEF0, 99);
        applyStimulus(1'b1, 1'b0, 3'b011, 64'h3008, 64'd0, 64'hCAFE_F00D_1234_5678, TO);
        applyStimulus(1'b1, 1'b1, 3'b001, 64'h2006, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1);

        // Reset lands in the second ACCESS cycle; the later ack must be ignored.
        mem_read_in = 1'b1; funct3_in = 3'b011; addr_in = 64'h40;
        @(posedge clk); #1;
        mem_read_in = 1'b0;
        checkOutput("mid_req1", dmem_req_out, 1'b1);
        @(posedge clk); #1;
        checkOutput("mid_req2", dmem_req_out, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        expLoad = 64'd0;
        checkOutput("mid_req_after", dmem_req_out, 1'b0);
        checkOutput("mid_stall_after", stall_out, 1'b0);
        checkOutput("mid_data_after", load_data_out, 64'd0);
        dmem_ack_in = 1'b1; dmem_rdata_in = 64'h5555_5555_5555_5555;
        @(posedge clk); #1;
        dmem_ack_in = 1'b0;
        checkOutput("late_ack_valid", load_valid_out, 1'b0);
        checkOutput("late_ack_req", dmem_req_out, 1'b0);
        @(posedge clk); #1;
        checkOutput("late_ack_valid2", load_valid_out, 1'b0);
        checkOutput("late_ack_buserr", bus_error_out, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            f3 = 3'($urandom);
            a  = {$urandom, $urandom};
            if (($urandom % 4) != 0 || (rd && !wr && f3 == 3'd7))
                a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            applyStimulus(rd, wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                          int'($urandom_range(0, TO + 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
